// File: rtl/bcd_converter_arbiter.sv
// bcd_converter_arbiter: round-robin arbiter sharing one binary-to-BCD converter between two requesters
// Ports:
//   clk_i, reset_i                  clock, synchronous active-high reset
//   reqN_start_i, reqN_binary_i     per-requester request pulse and 32-bit operand
//   reqN_busy_o, reqN_done_o        request pending/in service, one-cycle completion pulse
//   reqN_BCD_o                      last 40-bit BCD result for that requester
//   req_error_o                     sticky per-requester timeout flags
//   conv_start_o, conv_binary_o     start and operand towards the converter
//   conv_ready_i, conv_done_i       converter idle and one-cycle done pulse
//   conv_BCD_i                      converter result, valid with conv_done_i
module bcd_converter_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req0_start_i,
    input  logic        req1_start_i,
    input  logic [31:0] req0_binary_i,
    input  logic [31:0] req1_binary_i,
    output logic        req0_busy_o,
    output logic        req1_busy_o,
    output logic        req0_done_o,
    output logic        req1_done_o,
    output logic [39:0] req0_BCD_o,
    output logic [39:0] req1_BCD_o,
    output logic [1:0]  req_error_o,
    output logic        conv_start_o,
    output logic [31:0] conv_binary_o,
    input  logic        conv_ready_i,
    input  logic        conv_done_i,
    input  logic [39:0] conv_BCD_i
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, COMPLETE} state_t;

    state_t        state, next;
    logic [1:0]    pending, accept, done, fault;
    logic [31:0]   op0, op1;
    logic [39:0]   bcd0, bcd1;
    logic [1:0]    err;
    logic          grant, ptr, sel, expire;
    logic [CW-1:0] cnt;

    // A start is taken only when its requester has nothing outstanding
    assign accept = {req1_start_i, req0_start_i} & ~pending;
    // Both pending: ptr holds the requester that was not granted last
    assign sel    = (pending == 2'b11) ? ptr : pending[1];
    assign expire = cnt == CW'(TIMEOUT - 1);

    always_comb begin
        next          = state;
        done          = '0;
        fault         = '0;
        conv_start_o  = 1'b0;
        conv_binary_o = '0;
        unique case (state)
            IDLE:     next = |pending ? ISSUE : IDLE;
            ISSUE: begin
                conv_start_o  = 1'b1;
                conv_binary_o = grant ? op1 : op0;
                next          = conv_ready_i ? WAIT : ISSUE;
            end
            WAIT: begin
                next  = (conv_done_i || expire) ? COMPLETE : WAIT;
                fault = (!conv_done_i && expire) ? (grant ? 2'b10 : 2'b01) : 2'b00;
            end
            default: begin
                done = grant ? 2'b10 : 2'b01;
                next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state   <= IDLE;
            pending <= '0;
            ptr     <= 1'b0;
            grant   <= 1'b0;
            cnt     <= '0;
            op0     <= '0;
            op1     <= '0;
            bcd0    <= '0;
            bcd1    <= '0;
            err     <= '0;
        end else begin
            state   <= next;
            pending <= (pending & ~done) | accept;
            err     <= (err & ~accept) | fault;
            cnt     <= (state == WAIT) ? cnt + 1'b1 : '0;
            if (state == IDLE && |pending) begin
                grant <= sel;
                ptr   <= ~sel;
            end
            if (accept[0]) op0 <= req0_binary_i;
            if (accept[1]) op1 <= req1_binary_i;
            if (state == WAIT && conv_done_i && !grant) bcd0 <= conv_BCD_i;
            if (state == WAIT && conv_done_i && grant) bcd1 <= conv_BCD_i;
        end
    end

    assign {req1_busy_o, req0_busy_o} = pending;
    assign {req1_done_o, req0_done_o} = done;
    assign req0_BCD_o  = bcd0;
    assign req1_BCD_o  = bcd1;
    assign req_error_o = err;
endmodule

// File: tb/tb_bcd_converter_arbiter.sv
// tb_bcd_converter_arbiter: randomized and directed bench against a cycle-timed transaction model
module tb_bcd_converter_arbiter;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        req0_start_i = 1'b0, req1_start_i = 1'b0;
    logic [31:0] req0_binary_i = '0, req1_binary_i = '0;
    logic        req0_busy_o, req1_busy_o, req0_done_o, req1_done_o;
    logic [39:0] req0_BCD_o, req1_BCD_o;
    logic [1:0]  req_error_o;
    logic        conv_start_o;
    logic [31:0] conv_binary_o;
    logic        conv_ready_i = 1'b0, conv_done_i = 1'b0;
    logic [39:0] conv_BCD_i = '0;

    always #5 clk = ~clk;

    bcd_converter_arbiter #(.TIMEOUT(TO)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .req0_start_i(req0_start_i), .req1_start_i(req1_start_i),
        .req0_binary_i(req0_binary_i), .req1_binary_i(req1_binary_i),
        .req0_busy_o(req0_busy_o), .req1_busy_o(req1_busy_o),
        .req0_done_o(req0_done_o), .req1_done_o(req1_done_o),
        .req0_BCD_o(req0_BCD_o), .req1_BCD_o(req1_BCD_o),
        .req_error_o(req_error_o),
        .conv_start_o(conv_start_o), .conv_binary_o(conv_binary_o),
        .conv_ready_i(conv_ready_i), .conv_done_i(conv_done_i), .conv_BCD_i(conv_BCD_i)
    );

    int n_chk = 0, n_fail = 0, cyc = 0;

    // Model: pending set, operands, results, errors, and the timing of the transaction in service
    logic [1:0]  bm = '0, err_m = '0;
    logic [31:0] op_m [2] = '{default: '0};
    logic [39:0] bcd_m [2] = '{default: '0};
    int          svc = -1, h = 0, lat = 0, dn_at = 0, idle_since = 0, next_lat = -1, stall = 0, hs_cnt = 0;
    bit          issuing = 0, tout = 0, ptr_m = 0;
    int          order [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [39:0] to_bcd(input logic [31:0] v);
        logic [39:0] r = '0;
        longint unsigned x = v;
        for (int i = 0; i < 10; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int pick(input logic [1:0] b, input bit p);
        return (b == 2'b11) ? int'(p) : (b[1] ? 1 : 0);
    endfunction

    task automatic step();
        logic [1:0] nb, exp_done;
        logic       exp_start;
        exp_done  = (svc >= 0 && !issuing && cyc == dn_at) ? 2'(1 << svc) : 2'b00;
        exp_start = svc >= 0 && issuing;
        check("busy", {req1_busy_o, req0_busy_o}, bm);
        check("done", {req1_done_o, req0_done_o}, exp_done);
        check("bcd0", req0_BCD_o, bcd_m[0]);
        check("bcd1", req1_BCD_o, bcd_m[1]);
        check("error", req_error_o, err_m);
        check("conv_start", conv_start_o, exp_start);
        check("conv_binary", conv_binary_o, exp_start ? op_m[svc] : 32'h0);
        if (reset_i) begin
            bm = '0; err_m = '0; bcd_m = '{default: '0};
            svc = -1; issuing = 0; ptr_m = 0; idle_since = cyc + 1;
            return;
        end
        nb = bm;
        if (exp_done != 0) begin
            order.push_back(svc);
            nb[svc] = 1'b0;
            svc = -1;
            idle_since = cyc + 1;
        end else if (svc >= 0 && !issuing && cyc == dn_at - 1) begin
            if (tout) err_m[svc] = 1'b1;
            else bcd_m[svc] = to_bcd(op_m[svc]);
        end else if (issuing && conv_ready_i) begin
            issuing = 0;
            hs_cnt++;
            h = cyc;
            if (next_lat >= 0) lat = next_lat;
            else case ($urandom % 10)
                0:       lat = TO;
                1:       lat = TO + 1;
                default: lat = int'($urandom_range(1, 6));
            endcase
            next_lat = -1;
            tout  = lat > TO;
            dn_at = tout ? h + TO + 1 : h + lat + 1;
        end else if (svc < 0 && cyc >= idle_since && bm != 0) begin
            svc = pick(bm, ptr_m);
            ptr_m = (svc == 0);
            issuing = 1;
        end
        if (req0_start_i && !bm[0]) begin nb[0] = 1'b1; op_m[0] = req0_binary_i; err_m[0] = 1'b0; end
        if (req1_start_i && !bm[1]) begin nb[1] = 1'b1; op_m[1] = req1_binary_i; err_m[1] = 1'b0; end
        bm = nb;
    endtask

    task automatic drive_conv();
        bit waiting;
        conv_ready_i = (stall > 0) ? 1'b0 : ($urandom % 4 != 0);
        if (stall > 0) stall--;
        waiting = svc >= 0 && !issuing && cyc < dn_at;
        conv_done_i = 1'b0;
        conv_BCD_i  = 40'({$urandom, $urandom});
        if (waiting && cyc == h + lat) begin
            conv_done_i = 1'b1;
            conv_BCD_i  = to_bcd(op_m[svc]);
        end else if (!waiting && $urandom % 8 == 0) conv_done_i = 1'b1;
    endtask

    task automatic tick();
        @(negedge clk);
        step();
        @(posedge clk);
        #1;
        cyc++;
        req0_start_i = 1'b0;
        req1_start_i = 1'b0;
        drive_conv();
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (!(svc < 0 && bm == 0) && k < 400) begin tick(); k++; end
        if (k >= 400) check({tag, "_bound"}, 1, 0);
    endtask

    task automatic start(input bit r0, input logic [31:0] v0, input bit r1, input logic [31:0] v1);
        req0_start_i = r0; req0_binary_i = v0;
        req1_start_i = r1; req1_binary_i = v1;
        tick();
    endtask

    initial begin
        int k, hs;
        repeat (3) @(posedge clk);
        #1;
        tick();
        reset_i = 1'b0;
        tick();
        start(1, 32'h5, 0, 0);
        wait_idle("single");
        check("single_bcd0", req0_BCD_o, 40'h0000000005);
        check("single_bcd1", req1_BCD_o, 40'h0);

        reset_i = 1'b1; tick(); reset_i = 1'b0;
        order.delete();
        start(1, 32'd1234, 1, 32'd99);
        wait_idle("pair");
        check("pair_bcd0", req0_BCD_o, 40'h0000001234);
        check("pair_bcd1", req1_BCD_o, 40'h0000000099);
        check("pair_first", order.size() > 0 ? order[0] : -1, 0);
        check("pair_second", order.size() > 1 ? order[1] : -1, 1);
        start(1, 32'd7, 1, 32'd8);
        wait_idle("pair2");

        start(0, 0, 1, 32'd777);
        tick();
        start(0, 0, 1, 32'd555);
        wait_idle("ignored");
        check("ignored_bcd1", req1_BCD_o, 40'h0000000777);

        hs = hs_cnt;
        stall = 7;
        start(1, 32'd42, 0, 0);
        wait_idle("stall");
        check("stall_handshakes", hs_cnt - hs, 1);

        next_lat = 1000000;
        start(1, 32'd321, 0, 0);
        wait_idle("timeout");
        check("timeout_err", req_error_o, 2'b01);
        check("timeout_bcd0", req0_BCD_o, 40'h0000000042);
        start(1, 32'd6, 0, 0);
        check("timeout_clear", req_error_o, 2'b00);
        wait_idle("after_timeout");

        next_lat = 10;
        start(0, 0, 1, 32'd1111);
        k = 0;
        while (!(svc >= 0 && !issuing) && k < 100) begin tick(); k++; end
        if (k >= 100) check("wait_bound", 1, 0);
        tick(); tick();
        reset_i = 1'b1; tick(); reset_i = 1'b0;
        check("rst_busy", {req1_busy_o, req0_busy_o}, 2'b00);
        check("rst_done", {req1_done_o, req0_done_o}, 2'b00);
        check("rst_bcd", {req1_BCD_o, req0_BCD_o}, 0);
        check("rst_conv", {conv_start_o, conv_binary_o}, 0);
        check("rst_err", req_error_o, 2'b00);
        start(0, 0, 1, 32'd2222);
        wait_idle("after_reset");
        check("after_reset_bcd1", req1_BCD_o, 40'h0000002222);

        for (int i = 0; i < 3000; i++) begin
            req0_start_i  = ($urandom % 4 == 0);
            req1_start_i  = ($urandom % 4 == 0);
            req0_binary_i = ($urandom % 8 == 0) ? 32'hFFFFFFFF : $urandom;
            req1_binary_i = ($urandom % 8 == 0) ? 32'h0 : $urandom;
            tick();
        end
        wait_idle("random");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
